argmax_unit: RTL and testbench
==============================

Name: argmax_unit

Overview:
- Streaming argmax/argmin engine for the NPU output stage (classification head, max-pool reduction).
- Consumes a vector of LEN signed or unsigned elements, LANES elements per beat, through a valid/ready handshake.
- Returns the extreme value and its 0-based position.
- Generalises the two-input running comparator with lane count, runtime vector length, min/max mode, tail masking, deterministic tie-break and an output handshake.

Parameters:
- DATA_W, 16, element width in bits.
- LANES, 2, elements per input beat (>=1).
- IDX_W, 8, width of LEN and OUT_INDEX; max vector length is 2^IDX_W-1.
- SIGNED, 1, 1 = two's-complement compare, 0 = unsigned compare.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST_ARGMAX  in  1  asynchronous active-high reset.
- EN_ARGMAX  in  1  clock enable; low freezes all state.
- START  in  1  one-cycle pulse that begins a vector; sampled only in IDLE.
- LEN  in  IDX_W  element count, latched on accepted START.
- MODE  in  1  0 = max, 1 = min, latched on accepted START.
- IN_VALID  in  1  input beat valid.
- IN_DATA  in  LANES*DATA_W  lane l occupies bits [l*DATA_W +: DATA_W]; lane 0 holds the lowest index.
- IN_READY  out  1  unit accepts a beat this cycle.
- OUT_VALID  out  1  result valid.
- OUT_READY  in  1  consumer accepts result.
- OUT_VALUE  out  DATA_W  extreme element.
- OUT_INDEX  out  IDX_W  0-based position of OUT_VALUE.
- BUSY  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, effective immediately):
  - state = IDLE.
  - IN_READY, OUT_VALID, BUSY = 0.
  - OUT_VALUE, OUT_INDEX = 0.
  - Internal count, best value, best index and first-flag cleared.
- EN_ARGMAX = 0: no register changes, IN_READY forced 0, OUT_VALID holds its value. Handshakes complete only when EN_ARGMAX = 1.
- FSM states: IDLE, ACCUM, RESULT.
- IDLE:
  - IN_READY = 0.
  - START with LEN != 0: latch LEN and MODE, cnt = 0, first = 1, go to ACCUM.
  - START with LEN == 0 is ignored.
- ACCUM:
  - IN_READY = 1. A beat is accepted when IN_VALID & IN_READY.
  - Lane l has position cnt+l. Lanes with position >= LEN are masked and never win.
  - In-beat reduction: the lowest lane wins ties.
  - Beat winner vs running best uses a strict compare (> for max, < for min), so the earlier index wins ties.
  - If first = 1, the beat winner is taken unconditionally; no sentinel value is used. first is then cleared.
  - cnt is IDX_W+1 bits wide and cannot wrap; cnt += LANES per accepted beat.
  - If cnt+LANES >= LEN on an accepted beat, go to RESULT.
  - START is ignored in this state.
- RESULT:
  - OUT_VALUE and OUT_INDEX are registered and stable; OUT_VALID = 1, asserted the cycle after the final accepted beat (latency 1).
  - Outputs are held while OUT_READY = 0.
  - On OUT_VALID & OUT_READY: go to IDLE, OUT_VALID = 0 next cycle, OUT_VALUE/OUT_INDEX retain the last result.
  - START in the same cycle as the result handshake is ignored; accepted from the next cycle.
- Compare arithmetic: SIGNED = 1 uses signed compare of DATA_W bits; SIGNED = 0 uses unsigned. No saturation or extension of OUT_VALUE.
- IN_DATA is ignored when IN_VALID = 0 or IN_READY = 0.

Test Plan (DATA_W=16, LANES=2, IDX_W=8, SIGNED=1):
1. START, LEN=4, MODE=0; beats {3,-5}, {7,7} back-to-back -> OUT_VALID the cycle after beat 2, OUT_VALUE=7, OUT_INDEX=2 (tie resolved to lower index).
2. LEN=3, MODE=0; beats {-2,-9}, {-1,0x7FFF} -> lane 1 of beat 2 masked; OUT_VALUE=-1 (0xFFFF), OUT_INDEX=2.
3. LEN=4, MODE=1; beats {5,0x8000}, {0x8000,4} -> OUT_VALUE=0x8000, OUT_INDEX=1.
4. LEN=2, MODE=0; beat {0x8000,0x8000} -> OUT_VALUE=0x8000, OUT_INDEX=0, proving no sentinel artefact. Repeat with LEN=0 START -> BUSY stays 0.
5. LEN=6 with IN_VALID gaps and EN_ARGMAX low for 2 cycles mid-vector, plus START pulsed during ACCUM -> count unaffected, START ignored. OUT_READY low 3 cycles -> OUT_VALID/VALUE/INDEX stable; IDLE one cycle after handshake.
6. Assert RST_ARGMAX asynchronously mid-ACCUM (between clock edges) -> BUSY, IN_READY, OUT_VALID drop immediately. Fresh START, LEN=2, beat {1,2} -> OUT_VALUE=2, OUT_INDEX=1.

Source files
------------

// File: rtl/argmax_unit.sv
// Streaming argmax/argmin engine: reduces a LEN-element vector,
// LANES elements per beat, to its extreme value and 0-based position.
module argmax_unit #(
  parameter int DATA_W = 16,
  parameter int LANES  = 2,
  parameter int IDX_W  = 8,
  parameter bit SIGNED = 1'b1
) (
  input  logic                      CLK,
  input  logic                      RST_ARGMAX,
  input  logic                      EN_ARGMAX,
  input  logic                      START,
  input  logic [IDX_W-1:0]          LEN,
  input  logic                      MODE,
  input  logic                      IN_VALID,
  input  logic [LANES*DATA_W-1:0]   IN_DATA,
  output logic                      IN_READY,
  output logic                      OUT_VALID,
  input  logic                      OUT_READY,
  output logic [DATA_W-1:0]         OUT_VALUE,
  output logic [IDX_W-1:0]          OUT_INDEX,
  output logic                      BUSY
);

  // Position arithmetic is one bit wider than cnt so cnt+lane never wraps.
  localparam int CW = IDX_W + 1;
  localparam int PW = IDX_W + 2;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    RESULT
  } state_t;

  state_t              state;
  logic [IDX_W-1:0]    len_q;
  logic                mode_q;
  logic [CW-1:0]       cnt;
  logic                first;
  logic [DATA_W-1:0]   best_val;
  logic [IDX_W-1:0]    best_idx;
  logic                out_valid_q;
  logic [DATA_W-1:0]   out_value_q;
  logic [IDX_W-1:0]    out_index_q;

  logic [DATA_W-1:0]   bw_val;
  logic [PW-1:0]       bw_pos;
  logic [PW-1:0]       pos;
  logic                take;
  logic [DATA_W-1:0]   nxt_val;
  logic [IDX_W-1:0]    nxt_idx;
  logic                last;
  logic                accept;

  // Strict "a beats b": greater for max mode, smaller for min mode.
  function automatic logic better(
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b,
    input logic              mn
  );
    logic gt;
    logic lt;
    if (SIGNED) begin
      gt = $signed(a) > $signed(b);
      lt = $signed(a) < $signed(b);
    end else begin
      gt = a > b;
      lt = a < b;
    end
    return mn ? lt : gt;
  endfunction

  assign IN_READY  = EN_ARGMAX && (state == ACCUM);
  assign accept    = IN_READY && IN_VALID;
  assign BUSY      = (state != IDLE);
  assign OUT_VALID = out_valid_q;
  assign OUT_VALUE = out_value_q;
  assign OUT_INDEX = out_index_q;

  // In-beat reduction (lowest lane wins ties, masked tail lanes never
  // win) followed by the strict merge into the running best.
  always_comb begin
    bw_val = IN_DATA[0 +: DATA_W];
    bw_pos = PW'(cnt);
    pos    = '0;
    for (int l = 1; l < LANES; l++) begin
      pos = PW'(cnt) + PW'(l);
      if (pos < PW'(len_q) &&
          better(IN_DATA[l*DATA_W +: DATA_W], bw_val, mode_q)) begin
        bw_val = IN_DATA[l*DATA_W +: DATA_W];
        bw_pos = pos;
      end
    end
    take    = first || better(bw_val, best_val, mode_q);
    nxt_val = take ? bw_val : best_val;
    nxt_idx = take ? bw_pos[IDX_W-1:0] : best_idx;
    last    = (PW'(cnt) + PW'(LANES)) >= PW'(len_q);
  end

  // Control FSM with registered result outputs; EN_ARGMAX low freezes all.
  always_ff @(posedge CLK or posedge RST_ARGMAX) begin
    if (RST_ARGMAX) begin
      state       <= IDLE;
      len_q       <= '0;
      mode_q      <= 1'b0;
      cnt         <= '0;
      first       <= 1'b0;
      best_val    <= '0;
      best_idx    <= '0;
      out_valid_q <= 1'b0;
      out_value_q <= '0;
      out_index_q <= '0;
    end else if (EN_ARGMAX) begin
      unique case (state)
        IDLE: begin
          if (START && (LEN != '0)) begin
            len_q  <= LEN;
            mode_q <= MODE;
            cnt    <= '0;
            first  <= 1'b1;
            state  <= ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            cnt      <= cnt + CW'(LANES);
            first    <= 1'b0;
            best_val <= nxt_val;
            best_idx <= nxt_idx;
            if (last) begin
              state       <= RESULT;
              out_valid_q <= 1'b1;
              out_value_q <= nxt_val;
              out_index_q <= nxt_idx;
            end
          end
        end
        RESULT: begin
          if (OUT_READY) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_argmax_unit.sv
// Directed self-checking bench for argmax_unit
// (DATA_W=16, LANES=2, IDX_W=8, SIGNED=1).
module tb_argmax_unit;

  logic        CLK = 1'b0;
  logic        RST_ARGMAX;
  logic        EN_ARGMAX;
  logic        START;
  logic [7:0]  LEN;
  logic        MODE;
  logic        IN_VALID;
  logic [31:0] IN_DATA;
  logic        IN_READY;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [15:0] OUT_VALUE;
  logic [7:0]  OUT_INDEX;
  logic        BUSY;

  int checks = 0;
  int errors = 0;

  argmax_unit #(
    .DATA_W(16), .LANES(2), .IDX_W(8), .SIGNED(1'b1)
  ) dut (
    .CLK(CLK), .RST_ARGMAX(RST_ARGMAX), .EN_ARGMAX(EN_ARGMAX),
    .START(START), .LEN(LEN), .MODE(MODE),
    .IN_VALID(IN_VALID), .IN_DATA(IN_DATA), .IN_READY(IN_READY),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_VALUE(OUT_VALUE), .OUT_INDEX(OUT_INDEX), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0]       len;
    logic             mode;
    int               nb;
    logic [2:0][31:0] beats;
    logic [15:0]      exp_val;
    logic [7:0]       exp_idx;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int i);
    START = 1'b1;
    LEN   = vecs[i].len;
    MODE  = vecs[i].mode;
    tick();
    START = 1'b0;
    check($sformatf("v%0d busy", i), 32'(BUSY), 32'd1);
    check($sformatf("v%0d in_ready", i), 32'(IN_READY), 32'd1);
    for (int b = 0; b < vecs[i].nb; b++) begin
      IN_VALID = 1'b1;
      IN_DATA  = vecs[i].beats[b];
      tick();
      if (b < vecs[i].nb - 1)
        check($sformatf("v%0d early valid b%0d", i, b),
              32'(OUT_VALID), 32'd0);
    end
    IN_VALID = 1'b0;
    IN_DATA  = '0;
    check($sformatf("v%0d out_valid", i), 32'(OUT_VALID), 32'd1);
    check($sformatf("v%0d value", i), 32'(OUT_VALUE),
          32'(vecs[i].exp_val));
    check($sformatf("v%0d index", i), 32'(OUT_INDEX),
          32'(vecs[i].exp_idx));
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
    check($sformatf("v%0d valid drop", i), 32'(OUT_VALID), 32'd0);
    check($sformatf("v%0d idle", i), 32'(BUSY), 32'd0);
  endtask

  initial begin
    vecs[0] = '{8'd4, 1'b0, 2,
                {32'h0, 32'h0007_0007, 32'hFFFB_0003},
                16'h0007, 8'd2};
    vecs[1] = '{8'd3, 1'b0, 2,
                {32'h0, 32'h7FFF_FFFF, 32'hFFF7_FFFE},
                16'hFFFF, 8'd2};
    vecs[2] = '{8'd4, 1'b1, 2,
                {32'h0, 32'h0004_8000, 32'h8000_0005},
                16'h8000, 8'd1};
    vecs[3] = '{8'd2, 1'b0, 1,
                {32'h0, 32'h0, 32'h8000_8000},
                16'h8000, 8'd0};
    vecs[4] = '{8'd1, 1'b0, 1,
                {32'h0, 32'h0, 32'h0064_0005},
                16'h0005, 8'd0};
    vecs[5] = '{8'd5, 1'b1, 3,
                {32'h0063_FFFF, 32'hFFFF_001E, 32'h0014_000A},
                16'hFFFF, 8'd3};

    RST_ARGMAX = 1'b1;
    EN_ARGMAX  = 1'b1;
    START      = 1'b0;
    LEN        = '0;
    MODE       = 1'b0;
    IN_VALID   = 1'b0;
    IN_DATA    = '0;
    OUT_READY  = 1'b0;
    tick();
    tick();
    check("rst busy", 32'(BUSY), 32'd0);
    check("rst in_ready", 32'(IN_READY), 32'd0);
    check("rst out_valid", 32'(OUT_VALID), 32'd0);
    check("rst value", 32'(OUT_VALUE), 32'd0);
    check("rst index", 32'(OUT_INDEX), 32'd0);
    RST_ARGMAX = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) run_vec(i);

    // LEN = 0 start is ignored
    START = 1'b1;
    LEN   = 8'd0;
    tick();
    START = 1'b0;
    check("len0 busy", 32'(BUSY), 32'd0);
    check("len0 in_ready", 32'(IN_READY), 32'd0);

    // LEN=6 with gaps, enable freeze and a stray START
    START = 1'b1;
    LEN   = 8'd6;
    MODE  = 1'b0;
    tick();
    START    = 1'b0;
    IN_VALID = 1'b1;
    IN_DATA  = 32'h0002_0001;
    tick();
    IN_VALID = 1'b0;
    tick();
    tick();
    check("gap busy", 32'(BUSY), 32'd1);
    check("gap valid", 32'(OUT_VALID), 32'd0);
    IN_VALID  = 1'b1;
    IN_DATA   = 32'h0003_0009;
    EN_ARGMAX = 1'b0;
    #1;
    check("en0 in_ready", 32'(IN_READY), 32'd0);
    tick();
    tick();
    EN_ARGMAX = 1'b1;
    START     = 1'b1;
    LEN       = 8'd2;
    tick();
    START   = 1'b0;
    check("mid valid", 32'(OUT_VALID), 32'd0);
    IN_DATA = 32'h0009_0004;
    tick();
    IN_VALID = 1'b0;
    check("t5 out_valid", 32'(OUT_VALID), 32'd1);
    check("t5 value", 32'(OUT_VALUE), 32'h0009);
    check("t5 index", 32'(OUT_INDEX), 32'd2);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("hold valid %0d", k), 32'(OUT_VALID), 32'd1);
      check($sformatf("hold value %0d", k), 32'(OUT_VALUE), 32'h0009);
      check($sformatf("hold index %0d", k), 32'(OUT_INDEX), 32'd2);
    end
    EN_ARGMAX = 1'b0;
    OUT_READY = 1'b1;
    tick();
    check("en0 hold valid", 32'(OUT_VALID), 32'd1);
    EN_ARGMAX = 1'b1;
    START     = 1'b1;
    LEN       = 8'd2;
    tick();
    START     = 1'b0;
    OUT_READY = 1'b0;
    check("hs valid drop", 32'(OUT_VALID), 32'd0);
    check("hs start ignored", 32'(BUSY), 32'd0);
    check("hs value kept", 32'(OUT_VALUE), 32'h0009);

    // Asynchronous reset in the middle of a vector
    START = 1'b1;
    LEN   = 8'd4;
    tick();
    START    = 1'b0;
    IN_VALID = 1'b1;
    IN_DATA  = 32'h0001_0001;
    tick();
    IN_VALID = 1'b0;
    #2;
    RST_ARGMAX = 1'b1;
    #1;
    check("arst busy", 32'(BUSY), 32'd0);
    check("arst in_ready", 32'(IN_READY), 32'd0);
    check("arst out_valid", 32'(OUT_VALID), 32'd0);
    tick();
    RST_ARGMAX = 1'b0;
    START      = 1'b1;
    LEN        = 8'd2;
    MODE       = 1'b0;
    tick();
    START    = 1'b0;
    IN_VALID = 1'b1;
    IN_DATA  = 32'h0002_0001;
    tick();
    IN_VALID = 1'b0;
    check("t6 out_valid", 32'(OUT_VALID), 32'd1);
    check("t6 value", 32'(OUT_VALUE), 32'h0002);
    check("t6 index", 32'(OUT_INDEX), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
